add_2i13_o13_unit: RTL and testbench

Unsigned 13-bit two-operand adder (modulo 2^13) for the Rq0 unpack datapath of the NTRU-HRSS encapsulation core. The combinational sum `out` keeps the `add_2i13_o13` port contract (x1, x2, out), so it drops into the running-sum accumulators for the even and odd coefficient streams and the final even+odd combine. The block also provides a registered copy of the sum and carry for pipelined users.

---
 rtl/add_2i13_o13_unit.sv | 87 ++++++++
 tb/tb_add_2i13_o13_unit.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_2i13_o13_unit.sv
// Unsigned 13-bit adder built on a Kogge-Stone prefix carry network, with a registered copy.
// out/cout are combinational (0 cycles); out_q/cout_q lag by 1 cycle; no backpressure, no enable.
module add_2i13_o13_unit (
    input  logic        clk,
    input  logic        ovr_rst,
    input  logic [12:0] x1,
    input  logic [12:0] x2,
    output logic [12:0] out,
    output logic        cout,
    output logic [12:0] out_q,
    output logic        cout_q
);

    logic [12:0] p0;
    logic [12:0] g0;
    logic [12:0] g1, p1;
    logic [12:0] g2, p2;
    logic [12:0] g4, p4;
    logic [12:0] g8, p8;
    logic [12:0] carry;

    assign g0 = x1 & x2;
    assign p0 = x1 ^ x2;

    // Each level merges the (G, P) pair 'span' bits below; lower bits already hold full prefixes.
    genvar i;
    generate
        for (i = 0; i < 13; i++) begin : g_lvl1
            if (i >= 1) begin : g_merge
                assign g1[i] = g0[i] | (p0[i] & g0[i-1]);
                assign p1[i] = p0[i] & p0[i-1];
            end else begin : g_pass
                assign g1[i] = g0[i];
                assign p1[i] = p0[i];
            end
        end

        for (i = 0; i < 13; i++) begin : g_lvl2
            if (i >= 2) begin : g_merge
                assign g2[i] = g1[i] | (p1[i] & g1[i-2]);
                assign p2[i] = p1[i] & p1[i-2];
            end else begin : g_pass
                assign g2[i] = g1[i];
                assign p2[i] = p1[i];
            end
        end

        for (i = 0; i < 13; i++) begin : g_lvl4
            if (i >= 4) begin : g_merge
                assign g4[i] = g2[i] | (p2[i] & g2[i-4]);
                assign p4[i] = p2[i] & p2[i-4];
            end else begin : g_pass
                assign g4[i] = g2[i];
                assign p4[i] = p2[i];
            end
        end

        for (i = 0; i < 13; i++) begin : g_lvl8
            if (i >= 8) begin : g_merge
                assign g8[i] = g4[i] | (p4[i] & g4[i-8]);
                assign p8[i] = p4[i] & p4[i-8];
            end else begin : g_pass
                assign g8[i] = g4[i];
                assign p8[i] = p4[i];
            end
        end
    endgenerate

    // Group propagate of the final level is unused; only generates feed the carries.
    logic unused_p8;
    assign unused_p8 = ^p8;

    assign carry = {g8[11:0], 1'b0};
    assign out   = p0 ^ carry;
    assign cout  = g8[12];

    always_ff @(posedge clk or posedge ovr_rst) begin
        if (ovr_rst) begin
            out_q  <= 13'h0000;
            cout_q <= 1'b0;
        end else begin
            out_q  <= out;
            cout_q <= cout;
        end
    end

endmodule

// File: tb/tb_add_2i13_o13_unit.sv
// Bench for add_2i13_o13_unit: directed corner cases plus random pairs against an arithmetic model.
module tb_add_2i13_o13_unit;

    logic        clk;
    logic        ovr_rst;
    logic [12:0] x1;
    logic [12:0] x2;
    logic [12:0] out;
    logic        cout;
    logic [12:0] out_q;
    logic        cout_q;

    int n_checks;
    int n_fail;

    add_2i13_o13_unit dut (
        .clk    (clk),
        .ovr_rst(ovr_rst),
        .x1     (x1),
        .x2     (x2),
        .out    (out),
        .cout   (cout),
        .out_q  (out_q),
        .cout_q (cout_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [13:0] ref_sum(input logic [12:0] a, input logic [12:0] b);
        int s;
        s = int'(a) + int'(b);
        return 14'(s);
    endfunction

    task automatic test_reset;
        ovr_rst = 1'b1;
        x1 = 13'h0011;
        x2 = 13'h0022;
        #2;
        n_checks++;
        if (out_q !== 13'h0000 || cout_q !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_regs: out_q=%h cout_q=%b required 0000/0", out_q, cout_q);
        end
        n_checks++;
        if ({cout, out} !== 14'h0033) begin
            n_fail++;
            $display("FAIL reset_comb: got %h required 0033", {cout, out});
        end
        @(negedge clk);
        ovr_rst = 1'b0;
    endtask

    task automatic test_basic;
        @(negedge clk);
        x1 = 13'h0005;
        x2 = 13'h0003;
        #1;
        n_checks++;
        if (out !== 13'h0008 || cout !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_comb: out=%h cout=%b required 0008/0", out, cout);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (out_q !== 13'h0008 || cout_q !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_reg: out_q=%h cout_q=%b required 0008/0", out_q, cout_q);
        end
    endtask

    task automatic test_wrap;
        @(negedge clk);
        x1 = 13'h1FFF;
        x2 = 13'h0001;
        #1;
        n_checks++;
        if (out !== 13'h0000 || cout !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_1fff_1: out=%h cout=%b required 0000/1", out, cout);
        end
        x2 = 13'h1FFF;
        #1;
        n_checks++;
        if (out !== 13'h1FFE || cout !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_1fff_1fff: out=%h cout=%b required 1ffe/1", out, cout);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (out_q !== 13'h1FFE || cout_q !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_reg: out_q=%h cout_q=%b required 1ffe/1", out_q, cout_q);
        end
    endtask

    task automatic test_carry_chain;
        @(negedge clk);
        x1 = 13'h0AAA;
        x2 = 13'h1556;
        #1;
        n_checks++;
        if (out !== 13'h0000 || cout !== 1'b1) begin
            n_fail++;
            $display("FAIL chain_aaa: out=%h cout=%b required 0000/1", out, cout);
        end
        x1 = 13'h1000;
        x2 = 13'h1000;
        #1;
        n_checks++;
        if (out !== 13'h0000 || cout !== 1'b1) begin
            n_fail++;
            $display("FAIL chain_msb: out=%h cout=%b required 0000/1", out, cout);
        end
        // Single-bit ripple from each position through all higher ones-bits.
        for (int k = 0; k < 13; k++) begin
            logic [13:0] e;
            x1 = 13'h1FFF << k;
            x2 = 13'h0001 << k;
            #1;
            e = ref_sum(x1, x2);
            n_checks++;
            if ({cout, out} !== e) begin
                n_fail++;
                $display("FAIL chain_bit%0d: got %h required %h", k, {cout, out}, e);
            end
        end
    endtask

    task automatic test_accumulator;
        logic [12:0] acc;
        logic [12:0] expv;
        acc = 13'h1FFF;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            x1 = 13'(k);
            x2 = acc;
            @(posedge clk);
            acc = out;
            expv = 13'(ref_sum(13'(k), x2));
            n_checks++;
            if (acc !== expv) begin
                n_fail++;
                $display("FAIL accum_step%0d: got %h required %h", k, acc, expv);
            end
        end
        n_checks++;
        if (acc !== 13'h0005) begin
            n_fail++;
            $display("FAIL accum_final: got %h required 0005", acc);
        end
        @(negedge clk);
        x1 = acc;
        x2 = 13'h0000;
        #1;
        n_checks++;
        if (~out !== 13'h1FFA) begin
            n_fail++;
            $display("FAIL accum_complement: got %h required 1ffa", ~out);
        end
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        x1 = 13'h0120;
        x2 = 13'h0003;
        @(posedge clk);
        #1;
        n_checks++;
        if (out_q !== 13'h0123) begin
            n_fail++;
            $display("FAIL async_preload: out_q=%h required 0123", out_q);
        end
        #2;
        ovr_rst = 1'b1;
        #1;
        n_checks++;
        if (out_q !== 13'h0000 || cout_q !== 1'b0) begin
            n_fail++;
            $display("FAIL async_immediate: out_q=%h cout_q=%b required 0000/0", out_q, cout_q);
        end
        n_checks++;
        if (out !== 13'h0123) begin
            n_fail++;
            $display("FAIL async_live_sum: out=%h required 0123", out);
        end
        x1 = 13'h1F00;
        x2 = 13'h0200;
        @(posedge clk);
        #1;
        n_checks++;
        if (out_q !== 13'h0000 || cout_q !== 1'b0) begin
            n_fail++;
            $display("FAIL async_hold: out_q=%h cout_q=%b required 0000/0", out_q, cout_q);
        end
        @(negedge clk);
        ovr_rst = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if ({cout_q, out_q} !== ref_sum(13'h1F00, 13'h0200)) begin
            n_fail++;
            $display("FAIL async_release: got %h required %h", {cout_q, out_q},
                     ref_sum(13'h1F00, 13'h0200));
        end
        // Reset asserted in the same step as a rising edge must still leave the register cleared.
        @(posedge clk);
        ovr_rst = 1'b1;
        #1;
        n_checks++;
        if (out_q !== 13'h0000 || cout_q !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_vs_edge: out_q=%h cout_q=%b required 0000/0", out_q, cout_q);
        end
        @(negedge clk);
        ovr_rst = 1'b0;
    endtask

    task automatic test_random;
        logic [13:0] e;
        for (int n = 0; n < 20000; n++) begin
            x1 = 13'($urandom);
            x2 = 13'($urandom);
            #1;
            e = ref_sum(x1, x2);
            n_checks++;
            if ({cout, out} !== e) begin
                n_fail++;
                $display("FAIL random_comb: x1=%h x2=%h got %h required %h", x1, x2, {cout, out}, e);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [13:0] q[$];
        logic [13:0] e;
        @(negedge clk);
        for (int n = 0; n < 300; n++) begin
            x1 = 13'($urandom);
            x2 = 13'($urandom);
            q.push_back(ref_sum(x1, x2));
            @(posedge clk);
            #1;
            e = q.pop_front();
            n_checks++;
            if ({cout_q, out_q} !== e) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: got %h required %h", n, {cout_q, out_q}, e);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        ovr_rst  = 1'b1;
        x1       = 13'h0000;
        x2       = 13'h0000;
        test_reset;
        test_basic;
        test_wrap;
        test_carry_chain;
        test_accumulator;
        test_async_reset;
        test_random;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
